// File: rtl/hazard_pipe_ctrl_if.sv
// Signal bundle between the ID stage / back end and hazard_pipe_ctrl.
// The master side drives the ID fields and hazard inputs; the slave side returns the controls.
interface hazard_pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_rs;
    logic [3:0]       id_rt;
    logic [3:0]       id_rd;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_rw;
    logic             id_memrd;
    logic             id_hlt;
    logic             ex_flush;
    logic             mem_busy;

    logic [3:0]       id_ex_rs;
    logic [3:0]       id_ex_rt;
    logic [3:0]       ex_mem_rd;
    logic [3:0]       mem_wb_rd;
    logic             ex_mem_rw;
    logic             mem_wb_rw;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             freeze;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_rw, id_memrd, id_hlt,
        output ex_flush, mem_busy,
        input  id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd, ex_mem_rw, mem_wb_rw,
        input  stall_if_id, flush_if_id, freeze, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_rw, id_memrd, id_hlt,
        input  ex_flush, mem_busy,
        output id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd, ex_mem_rw, mem_wb_rw,
        output stall_if_id, flush_if_id, freeze, halted, stall_cnt
    );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline hazard controller: tracks ID/EX, EX/MEM, MEM/WB, detects load-use hazards,
// applies freeze/flush/stall priority and drains the pipe after HLT.
module hazard_pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic       rw;
        logic       memrd;
        logic       hlt;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       rw;
        logic       memrd;
        logic       hlt;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       rw;
        logic       hlt;
    } mem_wb_t;

    state_e           state_q, state_d;
    id_ex_t           id_ex_q, id_ex_d;
    ex_mem_t          ex_mem_q, ex_mem_d;
    mem_wb_t          mem_wb_q, mem_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic running;
    logic do_flush;
    logic do_stall;
    logic do_advance;
    logic cnt_sat;
    logic unused_ex_memrd;

    // Hazard detection only looks at a real load sitting in ID/EX with a non-zero target.
    always_comb begin
        load_use = 1'b0;
        if (id_ex_q.valid && id_ex_q.memrd && (id_ex_q.rd != 4'd0) && bus.id_valid) begin
            load_use = (bus.id_uses_rs && (bus.id_rs == id_ex_q.rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == id_ex_q.rd));
        end
    end

    assign running    = (state_q == StRun);
    assign do_flush   = !bus.mem_busy && running && bus.ex_flush;
    assign do_stall   = !bus.mem_busy && running && !bus.ex_flush && load_use;
    assign do_advance = !bus.mem_busy && running && !bus.ex_flush && !load_use;
    assign cnt_sat    = &stall_cnt_q;

    // EX/MEM memrd is tracked for completeness but nothing downstream consumes it here.
    assign unused_ex_memrd = ex_mem_q.memrd;

    always_comb begin
        state_d     = state_q;
        id_ex_d     = id_ex_q;
        ex_mem_d    = ex_mem_q;
        mem_wb_d    = mem_wb_q;
        stall_cnt_d = stall_cnt_q;

        if (!bus.mem_busy) begin
            ex_mem_d = '{valid: id_ex_q.valid, rd: id_ex_q.rd, rw: id_ex_q.rw,
                         memrd: id_ex_q.memrd, hlt: id_ex_q.hlt};
            mem_wb_d = '{valid: ex_mem_q.valid, rd: ex_mem_q.rd, rw: ex_mem_q.rw,
                         hlt: ex_mem_q.hlt};
            id_ex_d  = '0;

            if (do_advance && bus.id_valid) begin
                id_ex_d = '{valid: 1'b1, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                            rw: bus.id_rw, memrd: bus.id_memrd, hlt: bus.id_hlt};
            end

            if (do_stall && !cnt_sat) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StRun: begin
                    if (do_advance && bus.id_valid && bus.id_hlt) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (mem_wb_q.valid && mem_wb_q.hlt) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    ex_mem_d = '0;
                    mem_wb_d = '0;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            id_ex_q     <= '0;
            ex_mem_q    <= '0;
            mem_wb_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_ex_q     <= id_ex_d;
            ex_mem_q    <= ex_mem_d;
            mem_wb_q    <= mem_wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        bus.id_ex_rs    = id_ex_q.rs;
        bus.id_ex_rt    = id_ex_q.rt;
        bus.ex_mem_rd   = ex_mem_q.rd;
        bus.mem_wb_rd   = mem_wb_q.rd;
        bus.ex_mem_rw   = ex_mem_q.valid && ex_mem_q.rw;
        bus.mem_wb_rw   = mem_wb_q.valid && mem_wb_q.rw;
        bus.freeze      = bus.mem_busy;
        bus.stall_if_id = bus.mem_busy || !running || do_stall;
        bus.flush_if_id = do_flush;
        bus.halted      = (state_q == StHalted);
        bus.stall_cnt   = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Randomized and directed checks of hazard_pipe_ctrl against an instruction-level pipeline model.
module tb_hazard_pipe_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int CntMax = (1 << CNT_W) - 1;
    localparam int ModeRun = 0;
    localparam int ModeDrain = 1;
    localparam int ModeHalted = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int rs;
        int rt;
        int rd;
        bit rw;
        bit memrd;
        bit hlt;
    } ins_t;

    // Instructions in flight: [0] ID/EX, [1] EX/MEM, [2] MEM/WB.
    ins_t pipe [3];
    int   mode;
    int   cnt;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b = '{default: 0};
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        mode = ModeRun;
        cnt  = 0;
    endtask

    function automatic bit model_lu();
        ins_t e;
        e = pipe[0];
        if (!(e.valid && e.memrd && e.rd != 0 && bus.id_valid === 1'b1)) return 1'b0;
        return (bus.id_uses_rs && int'(bus.id_rs) == e.rd) ||
               (bus.id_uses_rt && int'(bus.id_rt) == e.rd);
    endfunction

    task automatic compare_model();
        bit lu;
        bit busy;
        lu   = model_lu();
        busy = bus.mem_busy;
        check("freeze", bus.freeze, busy);
        check("stall_if_id", bus.stall_if_id, busy || mode != ModeRun || (!bus.ex_flush && lu));
        check("flush_if_id", bus.flush_if_id, !busy && mode == ModeRun && bus.ex_flush);
        check("halted", bus.halted, mode == ModeHalted);
        check("id_ex_rs", bus.id_ex_rs, pipe[0].rs);
        check("id_ex_rt", bus.id_ex_rt, pipe[0].rt);
        check("ex_mem_rd", bus.ex_mem_rd, pipe[1].rd);
        check("ex_mem_rw", bus.ex_mem_rw, pipe[1].valid && pipe[1].rw);
        check("mem_wb_rd", bus.mem_wb_rd, pipe[2].rd);
        check("mem_wb_rw", bus.mem_wb_rw, pipe[2].valid && pipe[2].rw);
        check("stall_cnt", bus.stall_cnt, cnt);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        ins_t nxt;
        bit   lu;
        bit   normal;
        lu = model_lu();
        if (bus.mem_busy) return;
        normal = (mode == ModeRun) && !bus.ex_flush && !lu;
        nxt = bubble();
        if (normal && bus.id_valid) begin
            nxt.valid = 1'b1;
            nxt.rs    = int'(bus.id_rs);
            nxt.rt    = int'(bus.id_rt);
            nxt.rd    = int'(bus.id_rd);
            nxt.rw    = bus.id_rw;
            nxt.memrd = bus.id_memrd;
            nxt.hlt   = bus.id_hlt;
        end
        if (mode == ModeRun && !bus.ex_flush && lu && cnt < CntMax) cnt++;
        if (mode == ModeDrain && pipe[2].valid && pipe[2].hlt) mode = ModeHalted;
        else if (normal && bus.id_valid && bus.id_hlt) mode = ModeDrain;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        if (mode == ModeHalted) for (int i = 0; i < 3; i++) pipe[i] = bubble();
    endtask

    task automatic apply(input bit v, input int rs, input int rt, input int rd,
                         input bit urs, input bit urt, input bit rw, input bit memrd,
                         input bit hlt, input bit flush, input bit busy);
        @(negedge clk);
        bus.id_valid   = v;
        bus.id_rs      = 4'(rs);
        bus.id_rt      = 4'(rt);
        bus.id_rd      = 4'(rd);
        bus.id_uses_rs = urs;
        bus.id_uses_rt = urt;
        bus.id_rw      = rw;
        bus.id_memrd   = memrd;
        bus.id_hlt     = hlt;
        bus.ex_flush   = flush;
        bus.mem_busy   = busy;
        #1;
        compare_model();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
    endtask

    task automatic issue(input int rs, input int rt, input int rd, input bit urs,
                         input bit urt, input bit rw, input bit memrd, input bit hlt);
        apply(1'b1, rs, rt, rd, urs, urt, rw, memrd, hlt, 1'b0, 1'b0);
    endtask

    task automatic nop(input bit flush, input bit busy);
        apply(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, flush, busy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.id_valid   = 1'b0;
        bus.id_rs      = '0;
        bus.id_rt      = '0;
        bus.id_rd      = '0;
        bus.id_uses_rs = 1'b0;
        bus.id_uses_rt = 1'b0;
        bus.id_rw      = 1'b0;
        bus.id_memrd   = 1'b0;
        bus.id_hlt     = 1'b0;
        bus.ex_flush   = 1'b0;
        bus.mem_busy   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_stall_if_id", bus.stall_if_id, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_ex_mem_rd", bus.ex_mem_rd, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Load r3 then a use of r3: one stall, one bubble, counter 0 -> 1.
        issue(1, 0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        advance();
        issue(3, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("lu_stall", bus.stall_if_id, 1);
        check("lu_cnt_before", bus.stall_cnt, 0);
        advance();
        issue(3, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("lu_released", bus.stall_if_id, 0);
        check("lu_cnt_after", bus.stall_cnt, 1);
        check("lu_ex_mem_rd", bus.ex_mem_rd, 3);
        check("lu_ex_mem_rw", bus.ex_mem_rw, 1);
        advance();

        // Load into r0 never creates a hazard.
        issue(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        advance();
        issue(0, 0, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("r0_no_stall", bus.stall_if_id, 0);
        check("r0_cnt", bus.stall_cnt, 1);
        advance();

        // Freeze for three cycles with ex_mem_rd=5, mem_wb_rd=2.
        issue(0, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        advance();
        issue(0, 0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        advance();
        nop(1'b0, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 7, 7, 9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            check("frz_freeze", bus.freeze, 1);
            check("frz_stall", bus.stall_if_id, 1);
            check("frz_flush", bus.flush_if_id, 0);
            check("frz_ex_mem_rd", bus.ex_mem_rd, 5);
            check("frz_mem_wb_rd", bus.mem_wb_rd, 2);
            advance();
        end
        nop(1'b0, 1'b0);
        check("frz_resume_stall", bus.stall_if_id, 0);
        advance();
        nop(1'b0, 1'b0);
        check("frz_resumed_mem_wb_rd", bus.mem_wb_rd, 5);
        check("frz_resumed_ex_mem_rd", bus.ex_mem_rd, 0);
        advance();

        // Flush wins over a pending load-use hazard.
        issue(0, 0, 6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        advance();
        apply(1'b1, 6, 0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fl_flush", bus.flush_if_id, 1);
        check("fl_stall", bus.stall_if_id, 0);
        advance();
        nop(1'b0, 1'b0);
        check("fl_bubble_rs", bus.id_ex_rs, 0);
        check("fl_ex_mem_rd", bus.ex_mem_rd, 6);
        check("fl_cnt", bus.stall_cnt, 1);
        advance();

        // HLT with a one-cycle freeze during the drain: halted 4 edges after HLT enters ID/EX.
        issue(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        advance();
        for (int k = 1; k <= 7; k++) begin
            nop(k >= 5, k == 2);
            check("hlt_halted", bus.halted, k >= 5);
            check("hlt_stall", bus.stall_if_id, 1);
            check("hlt_flush", bus.flush_if_id, 0);
            advance();
        end

        // Saturation of the stall counter after 16 load-use stalls.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            advance();
            issue(1, 0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            check("sat_stall", bus.stall_if_id, 1);
            advance();
        end
        nop(1'b0, 1'b0);
        check("sat_cnt", bus.stall_cnt, CntMax);
        advance();

        // Reset asserted mid-drain.
        do_reset();
        issue(0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        advance();
        nop(1'b0, 1'b0);
        advance();
        nop(1'b0, 1'b0);
        check("drain_stall", bus.stall_if_id, 1);
        check("drain_ex_mem_rd", bus.ex_mem_rd, 7);
        advance();
        do_reset();

        // Randomized episodes, each ending in an asynchronous reset.
        for (int ep = 0; ep < 8; ep++) begin
            int len;
            len = 150 + int'($urandom_range(0, 200));
            for (int c = 0; c < len; c++) begin
                apply($urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 63) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
                advance();
            end
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
